bram_port_arbiter: RTL

- Shares the single-port tap/data BRAM between two requesters: port 0 is the AXI4-Lite BRAM slave path and port 1 is the accelerator engine.
- Round-robin arbitration with a bounded hold (burst) window, so the engine can stream while the host is never starved.
- Drives the BRAM EN/WE/A/Di pins and steers the 1-cycle-latency Do back to the requester that issued the read.

---
 rtl/bram_port_arbiter_pkg.sv | 18 +
 rtl/bram_port_arbiter_if.sv | 48 ++++
 rtl/bram_port_arbiter_grant.sv | 76 +++++++
 rtl/bram_port_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM state encoding, port index and read latency.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_idx_t;

  localparam int unsigned RD_LATENCY = 1;

  function automatic arb_state_t own_state(input port_idx_t p);
    return p ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM pin bundle for bram_port_arbiter; slave = arbiter side, master = requesters + BRAM.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  p0_req;
  logic [NB-1:0]         p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic [NB-1:0]         p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  bram_en;
  logic [NB-1:0]         bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_di;
  logic [DATA_WIDTH-1:0] bram_do;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  bram_do,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output bram_en, bram_we, bram_addr, bram_di
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output bram_do,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  bram_en, bram_we, bram_addr, bram_di
  );

endinterface

// File: rtl/bram_port_arbiter_grant.sv
// Combinational grant and next-state decode for the two-port round-robin arbiter.
// BRAM_ARB_ENGINE_PRIO_EN: IDLE ties go to port 1 and only port 1 may hold the BRAM while port 0 waits.
module bram_arb_grant
  import bram_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 3
) (
  input  arb_state_t        i_state,
  input  logic [HOLD_W-1:0] i_hold_cnt,
  input  port_idx_t         i_rr_ptr,
  input  logic              i_req0,
  input  logic              i_req1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output arb_state_t        o_state_nxt,
  output logic [HOLD_W-1:0] o_hold_nxt,
  output port_idx_t         o_rr_nxt
);

  localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

  logic [1:0] w_req;
  port_idx_t  w_own;
  logic       w_may_hold;
  port_idx_t  w_tie;
  logic       w_grant;
  port_idx_t  w_sel;

  assign w_req = {i_req1, i_req0};
  assign w_own = (i_state == OWN1);

`ifdef BRAM_ARB_ENGINE_PRIO_EN
  assign w_may_hold = w_own && (i_hold_cnt < MAX_H);
  assign w_tie      = 1'b1;
`else
  assign w_may_hold = (i_hold_cnt < MAX_H);
  assign w_tie      = i_rr_ptr;
`endif

  always_comb begin
    w_grant    = 1'b0;
    w_sel      = 1'b0;
    o_hold_nxt = '0;
    o_rr_nxt   = i_rr_ptr;
    case (i_state)
      OWN0, OWN1: begin
        if (!w_req[!w_own]) begin
          w_grant    = w_req[w_own];
          w_sel      = w_own;
          o_hold_nxt = (i_hold_cnt >= MAX_H) ? MAX_H : i_hold_cnt + 1'b1;
        end else if (w_req[w_own] && w_may_hold) begin
          w_grant    = 1'b1;
          w_sel      = w_own;
          o_hold_nxt = i_hold_cnt + 1'b1;
        end else begin
          // hand over; rr_ptr remembers who just gave up the BRAM
          w_grant    = 1'b1;
          w_sel      = !w_own;
          o_hold_nxt = HOLD_W'(1);
          o_rr_nxt   = w_own;
        end
      end
      default: begin
        w_grant    = i_req0 | i_req1;
        w_sel      = (i_req0 && i_req1) ? w_tie : i_req1;
        o_hold_nxt = HOLD_W'(1);
      end
    endcase
    if (!w_grant) o_hold_nxt = '0;
    o_state_nxt = w_grant ? own_state(w_sel) : IDLE;
    o_gnt0      = w_grant && !w_sel;
    o_gnt1      = w_grant && w_sel;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester single-port BRAM arbiter: FSM registers, BRAM pin mux, read-data steering, contention counter.
// Optional macro BRAM_ARB_ENGINE_PRIO_EN selects engine (port 1) priority in bram_arb_grant.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  bram_port_arbiter_if.slave   bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t           r_state;
  logic [HOLD_W-1:0]    r_hold_cnt;
  port_idx_t            r_rr_ptr;
  logic                 r_rd_pend;
  port_idx_t            r_rd_owner;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  arb_state_t           w_state_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  port_idx_t            w_rr_nxt;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_rd_issue;

  bram_arb_grant #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_grant (
    .i_state     (r_state),
    .i_hold_cnt  (r_hold_cnt),
    .i_rr_ptr    (r_rr_ptr),
    .i_req0      (bus.p0_req),
    .i_req1      (bus.p1_req),
    .o_gnt0      (w_gnt0),
    .o_gnt1      (w_gnt1),
    .o_state_nxt (w_state_nxt),
    .o_hold_nxt  (w_hold_nxt),
    .o_rr_nxt    (w_rr_nxt)
  );

  assign w_rd_issue = (w_gnt0 && (bus.p0_we == '0)) || (w_gnt1 && (bus.p1_we == '0));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state        <= IDLE;
      r_hold_cnt     <= '0;
      r_rr_ptr       <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_owner     <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_rd_pend  <= w_rd_issue;
      if (w_rd_issue) r_rd_owner <= w_gnt1;
      if (bus.p0_req && bus.p1_req && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign bus.p0_gnt   = w_gnt0;
  assign bus.p1_gnt   = w_gnt1;

  always_comb begin
    bus.bram_en   = w_gnt0 | w_gnt1;
    bus.bram_we   = '0;
    bus.bram_addr = '0;
    bus.bram_di   = '0;
    if (w_gnt0) begin
      bus.bram_we   = bus.p0_we;
      bus.bram_addr = bus.p0_addr;
      bus.bram_di   = bus.p0_wdata;
    end else if (w_gnt1) begin
      bus.bram_we   = bus.p1_we;
      bus.bram_addr = bus.p1_addr;
      bus.bram_di   = bus.p1_wdata;
    end
  end

  always_comb begin
    bus.p0_rvalid = r_rd_pend && !r_rd_owner;
    bus.p1_rvalid = r_rd_pend && r_rd_owner;
    bus.p0_rdata  = bus.p0_rvalid ? bus.bram_do : '0;
    bus.p1_rdata  = bus.p1_rvalid ? bus.bram_do : '0;
  end

endmodule
